// File: rtl/nbj_pkg.sv
// Shared definitions for the non-branch-jump redirect merge.
// Token layout (MSB..LSB): {kind, type, idx[IDX_W-1:0], pc[PC_W-1:0]}.
// The record stored in the queue and the correction register is the token without its kind bit.
package nbj_pkg;

    localparam logic KIND_PROCESS = 1'b0;
    localparam logic KIND_LAST    = 1'b1;

    function automatic int unsigned pc_lsb();
        return 0;
    endfunction

    function automatic int unsigned idx_lsb(input int unsigned pc_w);
        return pc_w;
    endfunction

    function automatic int unsigned type_pos(input int unsigned idx_w, input int unsigned pc_w);
        return pc_w + idx_w;
    endfunction

    function automatic int unsigned kind_pos(input int unsigned idx_w, input int unsigned pc_w);
        return pc_w + idx_w + 1;
    endfunction

    function automatic int unsigned rec_width(input int unsigned idx_w, input int unsigned pc_w);
        return 1 + idx_w + pc_w;
    endfunction

    function automatic int unsigned tok_width(input int unsigned idx_w, input int unsigned pc_w);
        return 2 + idx_w + pc_w;
    endfunction

endpackage

// File: rtl/nbj_rr_arbiter.sv
// Round-robin picker over NUM_CH eligibility lines.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   elig_i    - per-channel eligibility
//   grant_o   - one-hot grant (combinational), zero when nothing is eligible
// The pointer holds the last granted channel; search starts one past it.
module nbj_rr_arbiter #(
    parameter int unsigned NUM_CH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] elig_i,
    output logic [NUM_CH-1:0] grant_o
);

    localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] cand;
    logic             found;

    // Walk channels in priority order p+1, p+2, ... and grant the first eligible one.
    always_comb begin
        grant_o = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        cand    = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            cand = PTR_W'((32'(ptr_q) + k) % NUM_CH);
            if (!found && elig_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                ptr_d         = cand;
            end
        end
    end

    // Reset to the last channel so channel 0 wins the first contest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= PTR_W'(NUM_CH - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/nbj_redirect_merge.sv
// Merges NUM_CH redirect-token sources; process tokens go to a FIFO_DEPTH queue,
// last tokens are absorbed; every accepted token updates the correction register.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   i_valid/i_data - per-channel tokens, channel c at [c*TOK_W +: TOK_W]
//   o_ready        - one-hot combinational grant
//   i_flush        - synchronous flush of queue and correction valid
//   o_valid/o_data - queue head record {type, idx, pc}; i_ready pops it
//   o_corr_*       - correction register (last accepted token of either kind)
//   o_count        - queue occupancy
module nbj_redirect_merge
    import nbj_pkg::*;
#(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned PC_W       = 32,
    parameter int unsigned IDX_W      = 3,
    parameter int unsigned FIFO_DEPTH = 2,
    localparam int unsigned REC_W     = 1 + IDX_W + PC_W,
    localparam int unsigned TOK_W     = 1 + REC_W,
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       i_valid,
    input  logic [NUM_CH*TOK_W-1:0] i_data,
    output logic [NUM_CH-1:0]       o_ready,
    input  logic                    i_flush,
    output logic                    o_valid,
    output logic [REC_W-1:0]        o_data,
    input  logic                    i_ready,
    output logic                    o_corr_valid,
    output logic                    o_corr_type,
    output logic [IDX_W-1:0]        o_corr_idx,
    output logic [PC_W-1:0]         o_corr_pc,
    output logic [CNT_W-1:0]        o_count
);

    localparam int unsigned PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned KIND_BIT = kind_pos(IDX_W, PC_W);
    localparam int unsigned TYPE_BIT = type_pos(IDX_W, PC_W);
    localparam int unsigned IDX_LO   = idx_lsb(PC_W);
    localparam int unsigned PC_LO    = pc_lsb();

    logic [REC_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              corr_valid_q;
    logic              corr_type_q;
    logic [IDX_W-1:0]  corr_idx_q;
    logic [PC_W-1:0]   corr_pc_q;

    logic [NUM_CH-1:0] kind_c;
    logic [NUM_CH-1:0] elig_c;
    logic [NUM_CH-1:0] grant_c;
    logic [TOK_W-1:0]  sel_tok_c;
    logic [REC_W-1:0]  sel_rec_c;
    logic              full_c;
    logic              deq_ok_c;
    logic              accept_c;
    logic              enq_c;
    logic              deq_c;

    assign full_c   = (count_q == CNT_W'(FIFO_DEPTH));
    assign deq_ok_c = (count_q != '0) && i_ready;

    // A process token may enter a full queue only when the head leaves the same cycle.
    always_comb begin
        kind_c = '0;
        elig_c = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            kind_c[c] = i_data[c*TOK_W + KIND_BIT];
            elig_c[c] = i_valid[c] && !i_flush &&
                        ((kind_c[c] == KIND_LAST) || !full_c || deq_ok_c);
        end
    end

    nbj_rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .elig_i  (elig_c),
        .grant_o (grant_c)
    );

    // One-hot grant makes an OR-of-masked-tokens mux sufficient.
    always_comb begin
        sel_tok_c = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (grant_c[c]) begin
                sel_tok_c = sel_tok_c | i_data[c*TOK_W +: TOK_W];
            end
        end
    end

    assign sel_rec_c = sel_tok_c[REC_W-1:0];
    assign accept_c  = |grant_c;
    assign enq_c     = accept_c && (sel_tok_c[KIND_BIT] == KIND_PROCESS);
    assign deq_c     = deq_ok_c && !i_flush;

    // Queue pointer/occupancy next-state; flush overrides everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq_c) begin
                wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (deq_c) begin
                rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({enq_c, deq_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Queue storage, pointers and correction register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            corr_valid_q <= 1'b0;
            corr_type_q  <= 1'b0;
            corr_idx_q   <= '0;
            corr_pc_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (enq_c) begin
                mem_q[wr_ptr_q] <= sel_rec_c;
            end
            if (i_flush) begin
                corr_valid_q <= 1'b0;
            end else if (accept_c) begin
                corr_valid_q <= 1'b1;
                corr_type_q  <= sel_tok_c[TYPE_BIT];
                corr_idx_q   <= sel_tok_c[IDX_LO +: IDX_W];
                corr_pc_q    <= sel_tok_c[PC_LO +: PC_W];
            end
        end
    end

    assign o_ready      = grant_c;
    assign o_valid      = (count_q != '0);
    assign o_data       = mem_q[rd_ptr_q];
    assign o_count      = count_q;
    assign o_corr_valid = corr_valid_q;
    assign o_corr_type  = corr_type_q;
    assign o_corr_idx   = corr_idx_q;
    assign o_corr_pc    = corr_pc_q;

endmodule

// File: tb/tb_nbj_redirect_merge.sv
// Directed bench for nbj_redirect_merge with three channels and a two-deep queue.
module tb_nbj_redirect_merge;

    localparam int unsigned NUM_CH     = 3;
    localparam int unsigned PC_W       = 32;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned REC_W      = 1 + IDX_W + PC_W;
    localparam int unsigned TOK_W      = 1 + REC_W;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);

    logic                    clk;
    logic                    rst;
    logic [NUM_CH-1:0]       i_valid;
    logic [NUM_CH*TOK_W-1:0] i_data;
    logic [NUM_CH-1:0]       o_ready;
    logic                    i_flush;
    logic                    o_valid;
    logic [REC_W-1:0]        o_data;
    logic                    i_ready;
    logic                    o_corr_valid;
    logic                    o_corr_type;
    logic [IDX_W-1:0]        o_corr_idx;
    logic [PC_W-1:0]         o_corr_pc;
    logic [CNT_W-1:0]        o_count;

    int n_tests = 0;
    int n_fail  = 0;

    nbj_redirect_merge #(
        .NUM_CH     (NUM_CH),
        .PC_W       (PC_W),
        .IDX_W      (IDX_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (i_valid),
        .i_data       (i_data),
        .o_ready      (o_ready),
        .i_flush      (i_flush),
        .o_valid      (o_valid),
        .o_data       (o_data),
        .i_ready      (i_ready),
        .o_corr_valid (o_corr_valid),
        .o_corr_type  (o_corr_type),
        .o_corr_idx   (o_corr_idx),
        .o_corr_pc    (o_corr_pc),
        .o_count      (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [TOK_W-1:0] mk_tok(input logic kind, input logic typ,
                                                input logic [IDX_W-1:0] idx, input logic [PC_W-1:0] pc);
        return {kind, typ, idx, pc};
    endfunction

    function automatic logic [63:0] mk_rec(input logic typ, input logic [IDX_W-1:0] idx,
                                           input logic [PC_W-1:0] pc);
        logic [REC_W-1:0] r;
        r = {typ, idx, pc};
        return 64'(r);
    endfunction

    task automatic set_ch(input int c, input logic v, input logic [TOK_W-1:0] tok);
        i_valid[c]               = v;
        i_data[c*TOK_W +: TOK_W] = tok;
    endtask

    task automatic clear_all();
        i_valid = '0;
        i_data  = '0;
    endtask

    logic [NUM_CH-1:0] exp_gnt;
    int                prev;

    initial begin
        rst     = 1'b1;
        i_flush = 1'b0;
        i_ready = 1'b0;
        clear_all();
        #2;
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_count", 64'(o_count), 64'd0);
        check("rst_data", 64'(o_data), 64'd0);
        check("rst_corr_valid", 64'(o_corr_valid), 64'd0);
        check("rst_corr_pc", 64'(o_corr_pc), 64'd0);
        tick();
        tick();
        rst = 1'b0;

        // Round-robin: all three channels streaming process tokens, downstream always ready.
        i_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            set_ch(c, 1'b1, mk_tok(1'b0, 1'b0, IDX_W'(c), 32'h1000 + 32'(4 * c)));
        end
        for (int i = 0; i < 6; i++) begin
            settle();
            exp_gnt = NUM_CH'(1 << (i % 3));
            check("rr_grant", 64'(o_ready), 64'(exp_gnt));
            if (i > 0) begin
                prev = (i - 1) % 3;
                check("rr_data", 64'(o_data), mk_rec(1'b0, IDX_W'(prev), 32'h1000 + 32'(4 * prev)));
                check("rr_count", 64'(o_count), 64'd1);
            end
            tick();
        end
        clear_all();
        settle();
        check("rr_tail_data", 64'(o_data), mk_rec(1'b0, 3'd2, 32'h1008));
        tick();
        check("rr_drained", 64'(o_count), 64'd0);
        check("rr_drained_valid", 64'(o_valid), 64'd0);

        // Full queue: two process tokens fill it, third stalls, last token still accepted.
        i_ready = 1'b0;
        set_ch(0, 1'b1, mk_tok(1'b0, 1'b0, 3'd1, 32'h2000));
        settle();
        check("full_gnt_a", 64'(o_ready), 64'b001);
        tick();
        set_ch(0, 1'b1, mk_tok(1'b0, 1'b0, 3'd2, 32'h2004));
        settle();
        check("full_gnt_b", 64'(o_ready), 64'b001);
        tick();
        check("full_count", 64'(o_count), 64'd2);
        set_ch(0, 1'b1, mk_tok(1'b0, 1'b0, 3'd3, 32'h2008));
        set_ch(1, 1'b1, mk_tok(1'b1, 1'b1, 3'd4, 32'h3000));
        settle();
        check("full_last_gnt", 64'(o_ready), 64'b010);
        tick();
        check("full_corr_pc", 64'(o_corr_pc), 64'h3000);
        check("full_corr_type", 64'(o_corr_type), 64'd1);
        check("full_corr_idx", 64'(o_corr_idx), 64'd4);
        check("full_count_hold", 64'(o_count), 64'd2);
        check("full_head_stable", 64'(o_data), mk_rec(1'b0, 3'd1, 32'h2000));
        set_ch(1, 1'b0, '0);
        settle();
        check("full_stall", 64'(o_ready), 64'b000);

        // Full with simultaneous dequeue: process token enters while head leaves.
        i_ready = 1'b1;
        settle();
        check("fdq_gnt", 64'(o_ready), 64'b001);
        tick();
        check("fdq_count", 64'(o_count), 64'd2);
        check("fdq_head", 64'(o_data), mk_rec(1'b0, 3'd2, 32'h2004));
        check("fdq_corr_pc", 64'(o_corr_pc), 64'h2008);

        // Flush with requests pending: no grant, queue and correction valid cleared.
        for (int c = 0; c < 3; c++) begin
            set_ch(c, 1'b1, mk_tok(1'b0, 1'b0, IDX_W'(c), 32'h4000 + 32'(4 * c)));
        end
        i_flush = 1'b1;
        settle();
        check("flush_no_gnt", 64'(o_ready), 64'b000);
        tick();
        i_flush = 1'b0;
        check("flush_count", 64'(o_count), 64'd0);
        check("flush_valid", 64'(o_valid), 64'd0);
        check("flush_corr_valid", 64'(o_corr_valid), 64'd0);
        settle();
        check("flush_resume_gnt", 64'(o_ready), 64'b010);

        // Last token into an empty queue: nothing enqueued, correction register loaded.
        clear_all();
        set_ch(2, 1'b1, mk_tok(1'b1, 1'b1, 3'd5, 32'h8000_0040));
        settle();
        check("last_gnt", 64'(o_ready), 64'b100);
        tick();
        clear_all();
        check("last_valid", 64'(o_valid), 64'd0);
        check("last_count", 64'(o_count), 64'd0);
        check("last_corr_valid", 64'(o_corr_valid), 64'd1);
        check("last_corr_type", 64'(o_corr_type), 64'd1);
        check("last_corr_idx", 64'(o_corr_idx), 64'd5);
        check("last_corr_pc", 64'(o_corr_pc), 64'h8000_0040);

        // Reset mid-stream with two queued tokens; pointer must return to channel 0 priority.
        i_ready = 1'b0;
        set_ch(1, 1'b1, mk_tok(1'b0, 1'b0, 3'd6, 32'h5000));
        settle();
        check("mrst_gnt_a", 64'(o_ready), 64'b010);
        tick();
        set_ch(1, 1'b1, mk_tok(1'b0, 1'b0, 3'd7, 32'h5004));
        tick();
        check("mrst_count_pre", 64'(o_count), 64'd2);
        for (int c = 0; c < 3; c++) begin
            set_ch(c, 1'b1, mk_tok(1'b0, 1'b0, IDX_W'(c), 32'h6000 + 32'(4 * c)));
        end
        rst = 1'b1;
        settle();
        check("mrst_count", 64'(o_count), 64'd0);
        check("mrst_valid", 64'(o_valid), 64'd0);
        check("mrst_data", 64'(o_data), 64'd0);
        check("mrst_corr_valid", 64'(o_corr_valid), 64'd0);
        check("mrst_corr_pc", 64'(o_corr_pc), 64'd0);
        tick();
        rst = 1'b0;
        settle();
        check("mrst_first_gnt", 64'(o_ready), 64'b001);
        tick();
        clear_all();
        check("mrst_enq_count", 64'(o_count), 64'd1);
        check("mrst_enq_data", 64'(o_data), mk_rec(1'b0, 3'd0, 32'h6000));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nbj_redirect_merge.md
# nbj_redirect_merge

Clocked, parametrised successor to the two-input non-branch-jump redirect merge in the instruction-fetch path. Merges NUM_CH redirect-token sources under round-robin arbitration and steers each token by its kind bit: "process" tokens enter a FIFO_DEPTH-deep queue feeding the next-PC logic, while "last" tokens are absorbed. Every accepted token of either kind updates a correction register (type, PC index, PC) that the next-PC/cut-position logic reads.

## Interface
Parameters:
- NUM_CH, 2, number of token sources (≥2)
- PC_W, 32, PC width
- IDX_W, 3, aligned-instruction index width
- FIFO_DEPTH, 2, process-path queue depth (≥1)
- Derived: REC_W = 1+IDX_W+PC_W; TOK_W = 1+REC_W

Ports:
- clk  in  1  clock; single domain; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_valid  in  NUM_CH  per-channel token present
- i_data  in  NUM_CH*TOK_W  flattened tokens, channel c at [c*TOK_W +: TOK_W]; token = {kind, type, idx, pc}
- o_ready  out  NUM_CH  one-hot grant; token of channel c accepted when i_valid[c]&&o_ready[c]
- i_flush  in  1  synchronous flush
- o_valid  out  1  process queue non-empty
- o_data  out  REC_W  head record {type, idx, pc}
- i_ready  in  1  downstream accepts head
- o_corr_valid  out  1  correction register holds a token
- o_corr_type  out  1  latched type
- o_corr_idx  out  IDX_W  latched PC index
- o_corr_pc  out  PC_W  latched PC
- o_count  out  clog2(FIFO_DEPTH+1)  queue occupancy

## Operation
- kind=0: process token → enqueue {type,idx,pc}. kind=1: last token → no enqueue.
- Eligibility of channel c: i_valid[c] && (kind=1 || !full || (o_valid && i_ready)).
- Round-robin: pointer p = last granted channel; priority order p+1, p+2, … mod NUM_CH; first eligible channel granted. p updates only on a grant. Reset p = NUM_CH-1 (channel 0 highest priority).
- o_ready is combinational from i_valid, i_data kind bits, queue state, i_ready and p; at most one bit set; all zero when i_flush=1.
- Accepted token (either kind): correction register ← {type,idx,pc}, o_corr_valid ← 1.
- Dequeue when o_valid && i_ready; o_data is head, stable while o_valid && !i_ready.
- Simultaneous enqueue and dequeue: count unchanged; allowed when full (head leaves, new token enters tail).
- Queue is a circular buffer; read/write pointers wrap at FIFO_DEPTH (non-power-of-two supported).
- i_flush: queue emptied (count 0, pointers 0), o_corr_valid ← 0, no grant, no dequeue counted; p unchanged.
- Reset values: o_valid 0, o_data 0, o_count 0, o_corr_valid 0, o_corr_type 0, o_corr_idx 0, o_corr_pc 0, p = NUM_CH-1, queue storage 0.
- Reset mid-operation: all state returns to reset values immediately; in-flight tokens discarded.

## Timing
- Grant: combinational, same cycle as i_valid.
- Accept at edge N → o_valid=1 and o_data valid from N+1 (1-cycle latency, no bypass from input to output).
- Correction register visible from N+1.
- Dequeue at edge N → next head (or o_valid=0) from N+1.
- Full queue with no dequeue: process tokens stall (o_ready=0) while last tokens from any channel still accepted.
- Throughput: one token per cycle total across channels.

## Structure
- Shared package nbj_pkg: token field offsets (KIND, TYPE, IDX, PC positions as functions of IDX_W/PC_W), kind encodings KIND_PROCESS=0, KIND_LAST=1.
- One sub-module: nbj_rr_arbiter (NUM_CH-wide round-robin picker with pointer register, eligibility in, one-hot grant out). Queue and correction register inline.

## Test plan
- Reset: assert rst mid-stream with count=2 → all outputs 0 asynchronously, after release channel 0 wins first simultaneous request.
- Round-robin: NUM_CH=3, all channels valid with kind=0 continuously, i_ready=1 → grant order 0,1,2,0,1,2; o_data pc sequence matches.
- Full queue: FIFO_DEPTH=2, i_ready=0, three process tokens offered → two accepted, o_count=2, third held with o_ready=0; a kind=1 token from another channel accepted same cycle, o_corr_pc updates, o_count stays 2.
- Full with dequeue: count=2, i_ready=1, process token offered → accepted, count stays 2, head advances.
- Last token: token {kind=1,type=1,idx=5,pc=0x8000_0040} → o_valid stays 0, o_corr_* = 1/5/0x8000_0040, o_corr_valid=1 next cycle.
- Flush: count=2, i_flush=1 with valid requests → no grant, next cycle o_count=0, o_valid=0, o_corr_valid=0; arbitration resumes from unchanged pointer.
